sensor_nivel_triplo: RTL and testbench

//  Upstream acquisition stage for the tank-level datapath. Fires three HC-SR04 ultrasonic

---
 rtl/sensor_nivel_triplo_pkg.sv | 38 +++
 rtl/sensor_nivel_triplo_bin2bcd.sv | 54 +++++
 rtl/sensor_nivel_triplo.sv | 251 +++++++++++++++++++++++++
 tb/tb_sensor_nivel_triplo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_nivel_triplo_pkg.sv
// Shared definitions for the triple ultrasonic level sensor: FSM state codes and 50 MHz timing defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sensor_nivel_triplo_pkg;

    // State codes double as the db_estado debug value
    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        DISPARA     = 4'd2,
        ESPERA_ECHO = 4'd3,
        MEDE        = 4'd4,
        ARMAZENA    = 4'd5,
        GUARDA      = 4'd6,
        MEDIANA     = 4'd7,
        CONVERTE    = 4'd8,
        FIM         = 4'd9
    } estado_t;

    localparam int TRIG_CYCLES_DEF    = 500;
    localparam int CYCLES_PER_CM_DEF  = 2941;
    localparam int TIMEOUT_CYCLES_DEF = 1_500_000;
    localparam int GUARD_CYCLES_DEF   = 500_000;
    localparam int MAX_SPREAD_CM_DEF  = 10;

    function automatic logic [2:0] sensor_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    function automatic logic [8:0] max9(input logic [8:0] a, input logic [8:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/sensor_nivel_triplo_bin2bcd.sv
// Sequential double-dabble: 9-bit binary to 3-digit BCD.
// Latency: done pulses 10 cycles after start (1 load + 9 shift cycles).
// Backpressure: start is ignored while busy; bcd holds until the next start.
module bin2bcd_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    logic [8:0]  sh;
    logic [3:0]  cnt;
    logic [11:0] adj;

    // Add 3 to every digit >= 5 before each shift so the digit carries correctly
    always_comb begin
        adj = bcd;
        for (int k = 0; k < 3; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift one binary bit into the BCD digits per cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            bcd  <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                sh   <= bin;
                bcd  <= '0;
                cnt  <= 4'd9;
                busy <= 1'b1;
            end else if (busy) begin
                {bcd, sh} <= {adj, sh} << 1;
                cnt       <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sensor_nivel_triplo.sv
// Fires three HC-SR04 sensors in turn, times each echo in cm, fuses to a median BCD distance + discard flag.
// Latency: sum of per-sensor times + 3*GUARD_CYCLES + ~12 cycles from mensurar to fim_medida.
// Backpressure: none; mensurar is ignored while a measurement is in progress.
module sensor_nivel_triplo
    import sensor_nivel_triplo_pkg::*;
#(
    parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
    parameter int CYCLES_PER_CM  = CYCLES_PER_CM_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int GUARD_CYCLES   = GUARD_CYCLES_DEF,
    parameter int MAX_SPREAD_CM  = MAX_SPREAD_CM_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mensurar,
    input  logic        echo1,
    input  logic        echo2,
    input  logic        echo3,
    output logic        trigger1,
    output logic        trigger2,
    output logic        trigger3,
    output logic [11:0] distancia,
    output logic        fim_medida,
    output logic        descartar_medida,
    output logic [3:0]  db_sensor,
    output logic [3:0]  db_estado
);

    estado_t     estado;
    logic [1:0]  idx;
    logic [31:0] tmr;
    logic [31:0] presc;
    logic [8:0]  cm;
    logic [8:0]  leit0, leit1, leit2;
    logic [2:0]  vld;
    logic        medida_ok;
    logic [2:0]  trig;
    logic [2:0]  sync1, sync2;
    logic        echo_s;
    logic [8:0]  fus_bin;
    logic        desc_pend;
    logic        conv_start, conv_busy, conv_done;
    logic [11:0] conv_bcd;

    logic [8:0]  fus_val, spread, x, y;
    logic [9:0]  soma;
    logic [1:0]  n_vld;
    logic        desc_calc;

    // Two-flop synchronizer on the raw echo lines
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {echo3, echo2, echo1};
            sync2 <= sync1;
        end
    end

    // Only the sensor currently addressed drives the shared echo timer
    always_comb begin
        case (idx)
            2'd0:    echo_s = sync2[0];
            2'd1:    echo_s = sync2[1];
            default: echo_s = sync2[2];
        endcase
    end

    // Fusion: median of 3, mean of 2, pass-through of 1; discard on <2 valid or wide spread
    always_comb begin
        fus_val = '0;
        spread  = '0;
        x       = vld[0] ? leit0 : leit1;
        y       = vld[2] ? leit2 : leit1;
        soma    = {1'b0, x} + {1'b0, y};
        n_vld   = {1'b0, vld[0]} + {1'b0, vld[1]} + {1'b0, vld[2]};
        case (vld)
            3'b111: begin
                fus_val = max9(min9(leit0, leit1), min9(max9(leit0, leit1), leit2));
                spread  = max9(max9(leit0, leit1), leit2) - min9(min9(leit0, leit1), leit2);
            end
            3'b011, 3'b101, 3'b110: begin
                fus_val = soma[9:1];
                spread  = max9(x, y) - min9(x, y);
            end
            3'b001:  fus_val = leit0;
            3'b010:  fus_val = leit1;
            3'b100:  fus_val = leit2;
            default: fus_val = '0;
        endcase
        desc_calc = (n_vld < 2'd2) || (spread > 9'(MAX_SPREAD_CM));
    end

    // Measurement sequencer: fire, wait, time, store, guard for each sensor, then fuse and convert
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado           <= INICIAL;
            idx              <= '0;
            tmr              <= '0;
            presc            <= '0;
            cm               <= '0;
            leit0            <= '0;
            leit1            <= '0;
            leit2            <= '0;
            vld              <= '0;
            medida_ok        <= 1'b0;
            trig             <= '0;
            fus_bin          <= '0;
            desc_pend        <= 1'b1;
            conv_start       <= 1'b0;
            distancia        <= 12'h000;
            fim_medida       <= 1'b0;
            descartar_medida <= 1'b1;
        end else begin
            fim_medida <= 1'b0;
            conv_start <= 1'b0;
            trig       <= '0;
            case (estado)
                INICIAL: begin
                    if (mensurar) estado <= PREPARA;
                end
                PREPARA: begin
                    idx    <= 2'd0;
                    vld    <= '0;
                    tmr    <= '0;
                    trig   <= sensor_onehot(2'd0);
                    estado <= DISPARA;
                end
                DISPARA: begin
                    if (tmr == 32'(TRIG_CYCLES - 1)) begin
                        tmr <= '0;
                        // An echo already high here is a stuck line, not a reading
                        if (echo_s) begin
                            medida_ok <= 1'b0;
                            estado    <= ARMAZENA;
                        end else begin
                            estado <= ESPERA_ECHO;
                        end
                    end else begin
                        tmr  <= tmr + 32'd1;
                        trig <= sensor_onehot(idx);
                    end
                end
                ESPERA_ECHO: begin
                    if (echo_s) begin
                        // The rising cycle itself counts as the first echo clock
                        tmr    <= 32'd1;
                        presc  <= 32'd1;
                        cm     <= '0;
                        estado <= MEDE;
                    end else if (tmr == 32'(TIMEOUT_CYCLES - 1)) begin
                        medida_ok <= 1'b0;
                        estado    <= ARMAZENA;
                    end else begin
                        tmr <= tmr + 32'd1;
                    end
                end
                MEDE: begin
                    if (!echo_s) begin
                        medida_ok <= 1'b1;
                        estado    <= ARMAZENA;
                    end else if (tmr >= 32'(TIMEOUT_CYCLES - 1)) begin
                        medida_ok <= 1'b0;
                        estado    <= ARMAZENA;
                    end else begin
                        tmr <= tmr + 32'd1;
                        if (presc == 32'(CYCLES_PER_CM - 1)) begin
                            presc <= '0;
                            if (cm != 9'd511) cm <= cm + 9'd1;
                        end else begin
                            presc <= presc + 32'd1;
                        end
                    end
                end
                ARMAZENA: begin
                    case (idx)
                        2'd0:    begin leit0 <= cm; vld[0] <= medida_ok; end
                        2'd1:    begin leit1 <= cm; vld[1] <= medida_ok; end
                        default: begin leit2 <= cm; vld[2] <= medida_ok; end
                    endcase
                    tmr    <= '0;
                    estado <= GUARDA;
                end
                GUARDA: begin
                    if (tmr == 32'(GUARD_CYCLES - 1)) begin
                        tmr <= '0;
                        if (idx < 2'd2) begin
                            idx    <= idx + 2'd1;
                            trig   <= sensor_onehot(idx + 2'd1);
                            estado <= DISPARA;
                        end else begin
                            estado <= MEDIANA;
                        end
                    end else begin
                        tmr <= tmr + 32'd1;
                    end
                end
                MEDIANA: begin
                    fus_bin   <= fus_val;
                    desc_pend <= desc_calc;
                    if (vld != 3'b000) begin
                        conv_start <= 1'b1;
                        estado     <= CONVERTE;
                    end else begin
                        // Nothing valid: keep the old distance, flag it unreliable
                        descartar_medida <= 1'b1;
                        fim_medida       <= 1'b1;
                        estado           <= FIM;
                    end
                end
                CONVERTE: begin
                    if (conv_done && !conv_busy) begin
                        distancia        <= conv_bcd;
                        descartar_medida <= desc_pend;
                        fim_medida       <= 1'b1;
                        estado           <= FIM;
                    end
                end
                FIM: begin
                    estado <= INICIAL;
                end
                default: estado <= INICIAL;
            endcase
        end
    end

    bin2bcd_seq u_bcd (
        .clock (clock),
        .reset (reset),
        .start (conv_start),
        .bin   (fus_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Debug: the addressed sensor while a per-sensor phase is active
    always_comb begin
        db_sensor = 4'b0000;
        if (estado inside {DISPARA, ESPERA_ECHO, MEDE, ARMAZENA, GUARDA}) begin
            db_sensor = {1'b0, sensor_onehot(idx)};
        end
    end

    assign db_estado = estado;
    assign trigger1  = trig[0];
    assign trigger2  = trig[1];
    assign trigger3  = trig[2];

endmodule

// File: tb/tb_sensor_nivel_triplo.sv
module tb_sensor_nivel_triplo;
    import sensor_nivel_triplo_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mensurar = 1'b0;
    logic [2:0]  echo = 3'b000;
    logic [2:0]  trig;
    logic [11:0] distancia;
    logic        fim_medida, descartar_medida;
    logic [3:0]  db_sensor, db_estado;

    always #5 clock = ~clock;

    sensor_nivel_triplo #(
        .TRIG_CYCLES(5), .CYCLES_PER_CM(10), .TIMEOUT_CYCLES(5000),
        .GUARD_CYCLES(20), .MAX_SPREAD_CM(10)
    ) dut (
        .clock(clock), .reset(reset), .mensurar(mensurar),
        .echo1(echo[0]), .echo2(echo[1]), .echo3(echo[2]),
        .trigger1(trig[0]), .trigger2(trig[1]), .trigger3(trig[2]),
        .distancia(distancia), .fim_medida(fim_medida),
        .descartar_medida(descartar_medida),
        .db_sensor(db_sensor), .db_estado(db_estado)
    );

    typedef struct {
        logic [11:0] d;
        logic        x;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   fim_cnt = 0;
    int   n_starts = 0;
    int   trig_bad = 0;
    int   wid[3] = '{0, 0, 0};
    int   dly[3] = '{3, 3, 3};

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Sensor model: after the trigger falls, wait dly cycles then hold echo for wid cycles (0 = silent)
    initial begin : echo_model
        int   ctr[3];
        bit   act[3];
        logic [2:0] trig_q;
        ctr = '{0, 0, 0};
        act = '{0, 0, 0};
        trig_q = 3'b000;
        forever begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                if (trig_q[i] && !trig[i]) begin
                    act[i] = 1'b1;
                    ctr[i] = 0;
                end
                if (act[i]) begin
                    ctr[i]++;
                    echo[i] = (wid[i] > 0) && (ctr[i] > dly[i]) && (ctr[i] <= dly[i] + wid[i]);
                    if (ctr[i] > dly[i] + wid[i]) act[i] = 1'b0;
                end
            end
            trig_q = trig;
        end
    end

    // Monitor: pops one expectation per fim pulse; also watches trigger exclusivity
    always @(negedge clock) begin
        if (fim_medida) begin
            fim_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fim: got fim with distancia=%0h, none expected", distancia);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("distancia", int'(distancia), int'(e.d));
                chk("descartar", int'(descartar_medida), int'(e.x));
            end
        end
        if ($countones(trig) > 1 || (trig != 3'b000 && db_estado != 4'(DISPARA))) trig_bad++;
    end

    task automatic start_meas(input logic [11:0] d, input logic x);
        exp_t e;
        e.d = d;
        e.x = x;
        sb.push_back(e);
        n_starts++;
        @(negedge clock) mensurar = 1'b1;
        @(negedge clock) mensurar = 1'b0;
    endtask

    task automatic wait_fim();
        int n = 0;
        while (sb.size() != 0 && n < 40000) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_fim: %0d results still pending after %0d cycles", sb.size(), n);
            sb.delete();
        end
        repeat (5) @(negedge clock);
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((echo != 3'b000 || db_estado != 4'd0) && n < 10000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 10000) begin
            checks++;
            errors++;
            $display("FAIL wait_quiet: echo=%b estado=%0d still busy", echo, db_estado);
        end
    endtask

    task automatic set_echo(input int w0, input int w1, input int w2);
        wid[0] = w0;
        wid[1] = w1;
        wid[2] = w2;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        chk("rst_distancia", int'(distancia), 'h000);
        chk("rst_descartar", int'(descartar_medida), 1);
        chk("rst_fim", int'(fim_medida), 0);
        chk("rst_trig", int'(trig), 0);
        chk("rst_db_sensor", int'(db_sensor), 0);
        chk("rst_db_estado", int'(db_estado), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // 20/21/19 cm -> median 20, tight spread
        set_echo(200, 210, 190);
        start_meas(12'h020, 1'b0);
        wait_fim();
        wait_quiet();

        // No echoes: distance held from the previous result, flagged
        set_echo(0, 0, 0);
        start_meas(12'h020, 1'b1);
        wait_fim();
        wait_quiet();

        // 20/25/90 cm -> median 25, spread 70 flags discard
        set_echo(200, 250, 900);
        start_meas(12'h025, 1'b1);
        wait_fim();
        wait_quiet();

        // Sensor 2 silent: mean of 30 and 33 floors to 31
        set_echo(300, 0, 330);
        start_meas(12'h031, 1'b0);
        wait_fim();
        wait_quiet();

        // Over-long echo on sensor 1 is invalid; the other two give 40
        set_echo(6000, 400, 400);
        start_meas(12'h040, 1'b0);
        wait_fim();
        wait_quiet();

        // All echoes exceed the timeout: nothing valid, previous distance held
        set_echo(5200, 5200, 5200);
        start_meas(12'h040, 1'b1);
        wait_fim();
        wait_quiet();

        // Extra mensurar mid-run must be ignored
        set_echo(200, 210, 190);
        start_meas(12'h020, 1'b0);
        repeat (100) @(negedge clock);
        @(negedge clock) mensurar = 1'b1;
        @(negedge clock) mensurar = 1'b0;
        wait_fim();
        repeat (300) @(negedge clock);
        wait_quiet();

        // Reset during sensor 2 measurement aborts with no result
        set_echo(200, 300, 200);
        start_meas(12'h000, 1'b0);
        n = 0;
        while (!(db_estado == 4'(MEDE) && db_sensor == 4'b0010) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        chk("reach_mede_s2", int'(db_estado == 4'(MEDE) && db_sensor == 4'b0010), 1);
        sb.delete();
        n_starts--;
        reset = 1'b0;
        #2;
        chk("abort_trig", int'(trig), 0);
        chk("abort_estado", int'(db_estado), 0);
        chk("abort_fim", int'(fim_medida), 0);
        chk("abort_descartar", int'(descartar_medida), 1);
        chk("abort_distancia", int'(distancia), 'h000);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (1500) @(negedge clock);

        chk("fim_count", fim_cnt, n_starts);
        chk("trigger_exclusive", trig_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
